// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between a CPU fetch port and data port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build gives the data port fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t            r_state, w_next;
    logic              r_owner, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
    logic              w_any, w_grant_d, w_done;

    assign w_any  = if_req | d_req;
    assign w_done = (r_state == ACCESS) && mem_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;
    // On a tie the port that did not own the previous access wins
    assign w_grant_d = d_req & (~if_req | ~r_last_owner);
    always_ff @(posedge clk) begin
        if (reset)
            r_last_owner <= 1'b0;
        else if (w_done)
            r_last_owner <= r_owner;
    end
`else
    assign w_grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = mem_ready ? ACK : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_owner     <= w_grant_d;
                r_mem_we    <= w_grant_d & d_we;
                r_mem_addr  <= w_grant_d ? d_addr : if_addr;
                r_mem_wdata <= w_grant_d ? d_wdata : '0;
            end
            if (w_done && !r_mem_we) begin
                if (r_owner)
                    r_d_rdata <= mem_rdata;
                else
                    r_if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (r_state == ACCESS);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = (r_state == ACK) & ~r_owner;
    assign d_ack     = (r_state == ACK) & r_owner;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign owner     = r_owner;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, mem_req, mem_we, owner, busy;
    int          n_cmp = 0, n_err = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if ({mem_req, mem_we, if_ack, d_ack, owner, busy} !== 6'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 000000", {mem_req, mem_we, if_ack, d_ack, owner, busy}); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, d_rdata); end
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h8C010004;
        tick();
        n_cmp++; if ({mem_req, mem_we, owner} !== 3'b100) begin n_err++; $display("FAIL fetch_c1_ctl: got %b want 100", {mem_req, mem_we, owner}); end
        n_cmp++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL fetch_c1_addr: got %h want 40", mem_addr); end
        tick();
        n_cmp++; if ({if_ack, d_ack, mem_req} !== 3'b100) begin n_err++; $display("FAIL fetch_c2_ack: got %b want 100", {if_ack, d_ack, mem_req}); end
        n_cmp++; if (if_rdata !== 32'h8C010004) begin n_err++; $display("FAIL fetch_c2_rdata: got %h want 8c010004", if_rdata); end
        if_req = 1'b0; mem_ready = 1'b0;
        tick();
        n_cmp++; if ({busy, if_ack} !== 2'b00) begin n_err++; $display("FAIL fetch_c3_idle: got %b want 00", {busy, if_ack}); end
    endtask

    task automatic test_write_wait();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        mem_ready = 1'b0; mem_rdata = 32'h12345678;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({mem_req, mem_we, owner, d_ack} !== 4'b1110) begin n_err++; $display("FAIL wr_wait_ctl[%0d]: got %b want 1110", i, {mem_req, mem_we, owner, d_ack}); end
            n_cmp++; if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h100) begin n_err++; $display("FAIL wr_wait_bus[%0d]: got %h/%h want 100/deadbeef", i, mem_addr, mem_wdata); end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        n_cmp++; if ({d_ack, if_ack, mem_req} !== 3'b100) begin n_err++; $display("FAIL wr_ack: got %b want 100", {d_ack, if_ack, mem_req}); end
        n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rdata_kept: got %h want 0", d_rdata); end
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        tick();
        n_cmp++; if ({d_ack, busy} !== 2'b00) begin n_err++; $display("FAIL wr_ack_once: got %b want 00", {d_ack, busy}); end
    endtask

    task automatic test_tie();
        logic [3:0] exp_own;
        logic       e;
`ifdef ARB_ROUND_ROBIN_EN
        exp_own = 4'b0101;
`else
        exp_own = 4'b1111;
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = exp_own[i];
            mem_rdata = 32'h1000 + i;
            tick();
            n_cmp++; if (owner !== e || mem_addr !== (e ? 32'h200 : 32'h40)) begin n_err++; $display("FAIL tie_grant[%0d]: got owner %b addr %h want owner %b", i, owner, mem_addr, e); end
            tick();
            n_cmp++; if ({d_ack, if_ack} !== {e, ~e}) begin n_err++; $display("FAIL tie_ack[%0d]: got %b want %b", i, {d_ack, if_ack}, {e, ~e}); end
            n_cmp++; if ((e ? d_rdata : if_rdata) !== 32'h1000 + i) begin n_err++; $display("FAIL tie_rdata[%0d]: got %h want %h", i, e ? d_rdata : if_rdata, 32'h1000 + i); end
            tick();
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tie_idle[%0d]: got busy %b want 0", i, busy); end
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b0;
        tick();
        if_addr = 32'h80; if_req = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL chg_hold: got req %b addr %h want 1/40", mem_req, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h55;
        tick();
        n_cmp++; if (if_ack !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL chg_ack: got ack %b addr %h want 1/40", if_ack, mem_addr); end
        n_cmp++; if (if_rdata !== 32'h55) begin n_err++; $display("FAIL chg_rdata: got %h want 55", if_rdata); end
        mem_ready = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL chg_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_ready = 1'b0;
        tick();
        n_cmp++; if ({mem_req, owner} !== 2'b11) begin n_err++; $display("FAIL rst_mid_pre: got %b want 11", {mem_req, owner}); end
        reset = 1'b1; d_req = 1'b0;
        tick();
        reset = 1'b0;
        n_cmp++; if ({mem_req, busy, owner} !== 3'b000 || mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mid_abort: got %b addr %h want 000/0", {mem_req, busy, owner}, mem_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if ({if_ack, d_ack, busy} !== 3'b000) begin n_err++; $display("FAIL rst_mid_noack[%0d]: got %b want 000", i, {if_ack, d_ack, busy}); end
        end
        d_req = 1'b1;
        tick();
        n_cmp++; if ({mem_req, owner, d_ack} !== 3'b110 || mem_addr !== 32'h300) begin n_err++; $display("FAIL rst_mid_regrant: got %b addr %h want 110/300", {mem_req, owner, d_ack}, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h0000CAFE;
        tick();
        n_cmp++; if (d_ack !== 1'b1 || d_rdata !== 32'h0000CAFE) begin n_err++; $display("FAIL rst_mid_done: got ack %b data %h want 1/cafe", d_ack, d_rdata); end
        d_req = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_idle_ready();
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({if_ack, d_ack, busy, mem_req} !== 4'b0000) begin n_err++; $display("FAIL idle_rdy_ctl[%0d]: got %b want 0000", i, {if_ack, d_ack, busy, mem_req}); end
        end
        n_cmp++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0000CAFE) begin n_err++; $display("FAIL idle_rdy_data: got %h %h want 0 cafe", if_rdata, d_rdata); end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_wait();
        test_tie();
        test_addr_change();
        test_reset_mid();
        test_idle_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one unified single-ported memory between the multicycle CPU's instruction-fetch port and its data port. It sits between the CPU and the memory model. It latches one request at a time, drives a req/ready handshake toward memory, and returns read data with a one-cycle ack pulse to the winning requester. This lets a single memory replace the separate instruction and data memories without changing the CPU's sequencing.

## Interface
Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- if_req  in  1  instruction-fetch read request; held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1, then held
- if_ack  out  1  one-cycle completion pulse for the fetch port
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read word; valid while d_ack=1, then held
- d_ack  out  1  one-cycle completion pulse for the data port
- mem_req  out  1  memory access in progress
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completes the access in this cycle
- owner  out  1  0 = fetch port owns memory, 1 = data port
- busy  out  1  state is not IDLE

## Operation
- FSM has three states: IDLE, ACCESS and ACK.
- **IDLE:**
  - Samples if_req and d_req.
  - If either is high, selects a winner and latches its addr, we and wdata into the mem_* registers. Fetch always uses we=0.
  - Sets owner, then moves to ACCESS.
  - If neither is high, stays in IDLE.
- **ACCESS:**
  - mem_req=1, and the mem_* outputs stay stable.
  - Waits any number of cycles for mem_ready.
  - On mem_ready=1, a read latches mem_rdata into the owner's rdata register; a write leaves rdata unchanged.
  - Then moves to ACK.
- **ACK:**
  - mem_req=0 and the owner's ack=1 for exactly this cycle. Moves to IDLE.
  - A requester still showing req in this cycle is not re-granted; the IDLE re-evaluation happens one cycle later.
- Arbitration when both requests are high in IDLE is set by Configuration. Requests arriving during ACCESS or ACK wait.
- Requester inputs are ignored after latching, so address or data changes during ACCESS have no effect.
- A requester dropping req before its ack does not abort the transaction. The ack still pulses.
- last_owner register: updated to owner on entry to ACK.

## Timing
- Reset values:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0
  - owner=0, last_owner=0, busy=0
- Latency: request seen in IDLE at cycle N gives mem_req=1 at N+1. mem_ready at cycle M (M≥N+1) gives ack=1 at M+1.
- Minimum is 3 cycles request-to-ack with zero-wait memory. Back-to-back throughput is one access per 3 cycles.
- At most one of if_ack/d_ack is high in any cycle. Acks are never high outside ACK.
- mem_ready while not in ACCESS is ignored.
- Reset asserted in any state takes effect at that edge:
  - The in-flight access is abandoned: mem_req=0 and no ack follows.
  - The memory side tolerates abandoned requests.

## Configuration
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a tie the port that is not last_owner wins. With last_owner=0 after reset, the first tie goes to the data port, and ties then alternate.
- Undefined: fixed priority. The data port always wins ties and last_owner is unused for selection. This lets a pending load/store complete before the next fetch.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset, then if_req=1, if_addr=0x40, mem_ready tied 1, mem_rdata=0x8C010004 → mem_req high at cycle 1 with mem_addr=0x40 and mem_we=0. if_ack=1 and if_rdata=0x8C010004 at cycle 2. busy=0 at cycle 3.
- d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, with mem_ready delayed 4 cycles → mem_we=1 and mem_wdata=0xDEADBEEF held for 4 cycles. d_ack pulses once one cycle after mem_ready. d_rdata is unchanged.
- Both requests high continuously for 4 transactions:
  - Without ARB_ROUND_ROBIN_EN, all grants go to data (owner=1).
  - With it, owners run 1,0,1,0.
- Change if_addr from 0x40 to 0x80 mid-ACCESS and drop if_req → mem_addr stays 0x40 and if_ack still pulses.
- Assert reset for one cycle during ACCESS (mem_ready=0) → next cycle mem_req=0, state IDLE, and no ack appears. A subsequent d_req completes normally.
- Pulse mem_ready while IDLE with no requests → no ack, and rdata registers are unchanged.
